display_sequencer: RTL and testbench
====================================

# display_sequencer

Sequencer placed in front of the multiplexed 7-segment `display` driver. It owns the eight 8-bit display slots that feed `display`: slots 0–3 are the 3×3-conv result quad (c9_11, c9_12, c9_21, c9_22) and slots 4–7 are the 2×2-conv result quad (c4_11, c4_12, c4_21, c4_22). It arbitrates between the two result producers with a round-robin grant and a valid/ready handshake. After every update it enforces a shared minimum hold window, so digits stay readable before the next update is accepted.

## Interface
- `HOLD_CYCLES`, default 50_000_000: minimum cycles between accepted updates (1 s at 50 MHz); legal range 1 to 2^32−1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  conv9 producer has a result quad.
- `req0_data`  in  32  quad for slots 0–3; [7:0]→slot0, [15:8]→slot1, [23:16]→slot2, [31:24]→slot3.
- `req0_ready`  out  1  conv9 transfer accepted this cycle when high together with `req0_valid`.
- `req1_valid`  in  1  conv4 producer has a result quad.
- `req1_data`  in  32  quad for slots 4–7, same byte order.
- `req1_ready`  out  1  conv4 transfer accepted this cycle when high together with `req1_valid`.
- `freeze`  in  1  level; blocks new grants.
- `disp_data`  out  64  slot k on [8k+7:8k]; drives the eight `display` value inputs.
- `upd_pulse`  out  1  one-cycle pulse on the cycle after an accepted transfer.
- `last_grant`  out  1  requester index of the most recent accepted transfer.

## Operation
- **State machine:** two states, IDLE and HOLD.
- **IDLE:**
  - If `freeze`=0 and at least one `reqN_valid`=1, the round-robin arbiter picks one requester.
  - `reqN_ready` is combinational: it equals (state==IDLE && !freeze && !reset && grant==N). At most one ready is high in any cycle.
  - Ready is asserted only to a requester that is valid.
- **Accept (valid&ready at an edge):**
  - Write the granted 32-bit quad into that requester's half of `disp_data`. The other half is unchanged.
  - Set `last_grant`=N and assert `upd_pulse` for the next cycle.
  - Load the hold counter with HOLD_CYCLES−1 and enter HOLD.
- **HOLD:**
  - Both readies are 0. The counter decrements each cycle.
  - When the counter is 0, the next state is IDLE.
  - `freeze` has no effect on HOLD.
- **Round-robin:**
  - When both requesters are valid, grant the one not equal to `last_grant`.
  - When exactly one is valid, grant it regardless of history.
  - The pointer moves only on an accepted transfer.
- **Valid withdrawal:** a valid that drops before acceptance is legal. No transfer occurs and the pointer is unchanged.
- **Freeze:** while asserted in IDLE, nothing is accepted. Contents are held. Pending valids wait.
- **Reset values:**
  - `disp_data`=0, `upd_pulse`=0, `last_grant`=1, so req0 wins the first tie.
  - State is IDLE and the counter is 0.
- **Reset mid-HOLD:** return to IDLE immediately and clear all slots to 0. Any transfer presented in the reset cycle is not accepted.

## Timing
- Accept at edge E: `disp_data` shows the new quad and `upd_pulse`=1 in cycle E+1. `upd_pulse`=0 at E+2 unless another accept occurs.
- HOLD occupies cycles E+1 … E+HOLD_CYCLES. IDLE resumes in cycle E+HOLD_CYCLES+1.
- The earliest next accept is at the edge ending cycle E+HOLD_CYCLES+1.
- With HOLD_CYCLES=1, at most one accept every 2 cycles.
- Ready depends combinationally on `reqN_valid`, `freeze` and state. There is no registered-ready latency.
- The counter is 32 bits wide. No wrap-around is possible, because it only counts down from a loaded value and stops at 0.

## Structure
- **Shared package `display_pkg`:**
  - SLOT_W=8, NUM_SLOTS=8, QUAD_SLOTS=4.
  - Requester index constants REQ_C9=0 and REQ_C4=1.
  - State enum {IDLE, HOLD}.
- **Sub-module `rr_arb2`:** 2-way round-robin arbiter.
  - Inputs: `valid[1:0]`, `last`, `enable`.
  - Output: one-hot `grant[1:0]`.
  - Purely combinational. The pointer register stays in `display_sequencer`.
- **Top level:** instantiates `display_sequencer` next to `display`. `disp_data` slices connect to the eight slot inputs in slot order.

## Test plan
- **Reset state:** after reset → `disp_data`=0, both readies 0 in the reset cycle. First valid req0 with data 0x08040201 → `disp_data[31:0]`=0x08040201, upd_pulse for 1 cycle, `last_grant`=0.
- **Tie arbitration:** HOLD_CYCLES=4, both valid continuously with req0=0x11111111 and req1=0x22222222 → accepts alternate req0, req1, req0, spaced exactly 5 cycles apart. Each accept updates only its own half.
- **Hold enforcement:** req1 valid at E+1 right after a req0 accept at E → `req1_ready` stays 0 through cycle E+HOLD_CYCLES, then the accept happens at the edge ending cycle E+HOLD_CYCLES+1.
- **Freeze:** `freeze`=1 in IDLE with req0 valid → no ready and slots unchanged for 10 cycles. Releasing `freeze` → accept in the same cycle.
- **Reset mid-HOLD:** reset 2 cycles after an accept (HOLD_CYCLES=8) → `disp_data`=0 next cycle, state IDLE. A valid req1 is accepted on the first cycle after reset deasserts.
- **Single requester priority:** req1 is the only valid requester twice in a row → both accepted, because round-robin does not block a lone requester.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: constants and types shared by the display sequencer slice.
//   SLOT_W / NUM_SLOTS / QUAD_SLOTS  geometry of the display slot bank
//   QUAD_W / DISP_W                  derived bus widths
//   REQ_C9 / REQ_C4                  requester indices (conv9 -> 0, conv4 -> 1)
//   seq_state_t                      sequencer FSM states
package display_pkg;

    localparam int SLOT_W     = 8;
    localparam int NUM_SLOTS  = 8;
    localparam int QUAD_SLOTS = 4;
    localparam int QUAD_W     = SLOT_W * QUAD_SLOTS;
    localparam int DISP_W     = SLOT_W * NUM_SLOTS;

    localparam logic REQ_C9 = 1'b0;
    localparam logic REQ_C4 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

endpackage

// File: rtl/display_sequencer_if.sv
// display_sequencer_if: the two producer valid/ready/data channels.
//   req0_*  conv9 quad for slots 0-3
//   req1_*  conv4 quad for slots 4-7
// Modports:
//   master  producer side (drives valid/data, observes ready)
//   slave   sequencer side (observes valid/data, drives ready)
interface display_sequencer_if;
    import display_pkg::*;

    logic              req0_valid;
    logic [QUAD_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [QUAD_W-1:0] req1_data;
    logic              req1_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/display_sequencer_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
//   valid[1:0]  request lines
//   last        index of the most recently served requester
//   enable      arbitration allowed this cycle
//   grant[1:0]  one-hot grant, only ever to a valid requester
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                // tie: serve whoever was not served last
                grant = last ? 2'b01 : 2'b10;
            end else begin
                // zero or one requester: pass it straight through
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// display_sequencer: owns the eight display slots, arbitrates the conv9 and
// conv4 result producers and enforces a minimum hold window between updates.
//   clk, reset   system clock, synchronous active-high reset
//   req          producer channels (slave side of display_sequencer_if)
//   freeze       level; blocks new grants while idle
//   disp_data    slot k on [8k+7:8k]
//   upd_pulse    one-cycle pulse on the cycle after an accepted transfer
//   last_grant   requester index of the most recent accepted transfer
module display_sequencer
    import display_pkg::*;
#(
    parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    display_sequencer_if.slave  req,
    input  logic                freeze,
    output logic [DISP_W-1:0]   disp_data,
    output logic                upd_pulse,
    output logic                last_grant
);

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [31:0] hold_cnt;
    logic        arb_en;
    logic [1:0]  grant;
    logic        acc0;
    logic        acc1;
    logic        accept;

    // Ready is purely combinational; reset suppresses it so nothing can be
    // accepted on a reset edge.
    assign arb_en = (state == IDLE) && !freeze && !reset;

    rr_arb2 u_arb (
        .valid  ({req.req1_valid, req.req0_valid}),
        .last   (last_grant),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req.req0_ready = grant[0];
    assign req.req1_ready = grant[1];

    assign acc0   = grant[0] && req.req0_valid;
    assign acc1   = grant[1] && req.req1_valid;
    assign accept = acc0 || acc1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (accept) begin
                state_nxt = HOLD;
            end
        end else begin
            if (hold_cnt == 32'd0) begin
                state_nxt = IDLE;
            end
        end
    end

    // Counter is loaded with HOLD_CYCLES-1 so that HOLD lasts exactly
    // HOLD_CYCLES cycles; it parks at zero and never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= 32'd0;
        end else if (accept) begin
            hold_cnt <= HOLD_CYCLES - 32'd1;
        end else if (hold_cnt != 32'd0) begin
            hold_cnt <= hold_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_data  <= '0;
            upd_pulse  <= 1'b0;
            last_grant <= REQ_C4;
        end else begin
            upd_pulse <= accept;
            if (acc0) begin
                disp_data[QUAD_W-1:0] <= req.req0_data;
                last_grant            <= REQ_C9;
            end else if (acc1) begin
                disp_data[DISP_W-1:QUAD_W] <= req.req1_data;
                last_grant                 <= REQ_C4;
            end
        end
    end

endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: bench for display_sequencer.
//   dut_a (HOLD_CYCLES=4) runs a vector table, tie/lone-requester sequences
//   and randomized traffic against a cycle-level reference model.
//   dut_b (HOLD_CYCLES=8) runs the reset-during-hold sequence.
module tb_display_sequencer;

    localparam int unsigned HA = 4;
    localparam int unsigned HB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    display_sequencer_if ia ();
    display_sequencer_if ib ();

    logic        reset_a = 1'b1;
    logic        freeze_a = 1'b0;
    logic [63:0] disp_a;
    logic        pulse_a;
    logic        last_a;

    logic        reset_b = 1'b1;
    logic        freeze_b = 1'b0;
    logic [63:0] disp_b;
    logic        pulse_b;
    logic        last_b;

    display_sequencer #(.HOLD_CYCLES(HA)) dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .req        (ia.slave),
        .freeze     (freeze_a),
        .disp_data  (disp_a),
        .upd_pulse  (pulse_a),
        .last_grant (last_a)
    );

    display_sequencer #(.HOLD_CYCLES(HB)) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .req        (ib.slave),
        .freeze     (freeze_b),
        .disp_data  (disp_b),
        .upd_pulse  (pulse_b),
        .last_grant (last_b)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference model: slot bytes, history bit, pulse and cycles left in hold.
    logic [7:0]  m_slot [8];
    logic        m_last  = 1'b1;
    logic        m_pulse = 1'b0;
    int unsigned m_busy  = 0;
    logic        m_g0, m_g1;
    logic        cur_v0, cur_v1, cur_fr, cur_rs;
    logic [31:0] cur_d0, cur_d1;

    function automatic logic [63:0] model_disp();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = m_slot[k];
        return r;
    endfunction

    task automatic drive_sample(input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1,
                                input logic fr, input logic rs, input bit do_chk);
        @(negedge clk);
        ia.req0_valid = v0; ia.req0_data = d0;
        ia.req1_valid = v1; ia.req1_data = d1;
        freeze_a = fr; reset_a = rs;
        cur_v0 = v0; cur_v1 = v1; cur_d0 = d0; cur_d1 = d1; cur_fr = fr; cur_rs = rs;
        #1;
        m_g0 = 1'b0; m_g1 = 1'b0;
        if (!rs && m_busy == 0 && !fr) begin
            if (v0 && v1) begin
                m_g0 = m_last;
                m_g1 = !m_last;
            end else begin
                m_g0 = v0;
                m_g1 = v1;
            end
        end
        if (do_chk) begin
            chk("model_ready0", ia.req0_ready, m_g0);
            chk("model_ready1", ia.req1_ready, m_g1);
            chk("model_disp", disp_a, model_disp());
            chk("model_pulse", pulse_a, m_pulse);
            chk("model_last", last_a, m_last);
        end
    endtask

    task automatic commit();
        @(posedge clk);
        if (cur_rs) begin
            for (int k = 0; k < 8; k++) m_slot[k] = 8'h00;
            m_last = 1'b1; m_pulse = 1'b0; m_busy = 0;
        end else begin
            m_pulse = m_g0 || m_g1;
            if (m_g0) begin
                for (int k = 0; k < 4; k++) m_slot[k] = cur_d0[8*k +: 8];
                m_last = 1'b0; m_busy = HA;
            end else if (m_g1) begin
                for (int k = 0; k < 4; k++) m_slot[k+4] = cur_d1[8*k +: 8];
                m_last = 1'b1; m_busy = HA;
            end else if (m_busy > 0) begin
                m_busy--;
            end
        end
    endtask

    task automatic cyc(input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1,
                       input logic fr, input logic rs);
        drive_sample(v0, d0, v1, d1, fr, rs, 1'b1);
        commit();
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        fr;
        logic        rs;
        logic        e_r0;
        logic        e_r1;
        logic        e_pulse;
        logic        e_last;
        logic [63:0] e_disp;
    } vec_t;

    vec_t vecs [23];
    int   acc_q [$];
    int   who_q [$];
    int   cnt;

    localparam logic [31:0] QA = 32'h08040201;
    localparam logic [31:0] QB = 32'hAABBCCDD;
    localparam logic [31:0] QC = 32'h12345678;

    initial begin
        ia.req0_valid = 1'b0; ia.req0_data = '0;
        ia.req1_valid = 1'b0; ia.req1_data = '0;
        ib.req0_valid = 1'b0; ib.req0_data = '0;
        ib.req1_valid = 1'b0; ib.req1_data = '0;
        for (int k = 0; k < 8; k++) m_slot[k] = 8'h00;

        // Reset, first accept, hold enforcement, freeze in hold and idle.
        vecs[0] = '{1'b1, QA, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        vecs[1] = '{1'b1, QA, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0};
        vecs[2] = '{1'b0, QA, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {32'h0, QA}};
        for (int r = 3; r <= 5; r++)
            vecs[r] = '{1'b0, 32'h0, 1'b1, QB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {32'h0, QA}};
        vecs[6] = '{1'b0, 32'h0, 1'b1, QB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {32'h0, QA}};
        vecs[7] = '{1'b1, QC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {QB, QA}};
        for (int r = 8; r <= 20; r++)
            vecs[r] = '{1'b1, QC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {QB, QA}};
        vecs[21] = '{1'b1, QC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {QB, QA}};
        vecs[22] = '{1'b0, QC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {QB, QC}};

        // Outputs are unknown before the first reset edge.
        drive_sample(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        commit();

        for (int i = 0; i < 23; i++) begin
            drive_sample(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1,
                         vecs[i].fr, vecs[i].rs, 1'b1);
            chk($sformatf("vec%0d_ready0", i), ia.req0_ready, vecs[i].e_r0);
            chk($sformatf("vec%0d_ready1", i), ia.req1_ready, vecs[i].e_r1);
            chk($sformatf("vec%0d_pulse", i), pulse_a, vecs[i].e_pulse);
            chk($sformatf("vec%0d_last", i), last_a, vecs[i].e_last);
            chk($sformatf("vec%0d_disp", i), disp_a, vecs[i].e_disp);
            commit();
        end

        // Tie: both requesters valid continuously, req0 wins first after reset.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            drive_sample(1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1);
            if (ia.req0_ready) begin acc_q.push_back(i); who_q.push_back(0); end
            if (ia.req1_ready) begin acc_q.push_back(i); who_q.push_back(1); end
            if (i == 1) chk("tie_disp_after_first", disp_a, {32'h0, 32'h11111111});
            if (i == 6) chk("tie_disp_after_second", disp_a, {32'h22222222, 32'h11111111});
            commit();
        end
        chk("tie_accept_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("tie_who0", who_q[0], 0);
            chk("tie_who1", who_q[1], 1);
            chk("tie_who2", who_q[2], 0);
            chk("tie_first_cycle", acc_q[0], 0);
            chk("tie_gap01", acc_q[1] - acc_q[0], HA + 1);
            chk("tie_gap12", acc_q[2] - acc_q[1], HA + 1);
        end

        // Lone req1, twice in a row, after a req1 accept history.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive_sample(1'b0, 32'h0, 1'b1, $urandom, 1'b0, 1'b0, 1'b1);
            if (ia.req1_ready) cnt++;
            commit();
        end
        chk("lone_req1_accepts", cnt, 2);
        drive_sample(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("lone_req1_last", last_a, 1'b1);
        commit();

        // Randomized traffic against the model.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 2) != 0, $urandom,
                $urandom_range(0, 2) != 0, $urandom,
                $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end

        // Reset two cycles into an 8-cycle hold.
        @(negedge clk); reset_b = 1'b1;
        @(negedge clk); reset_b = 1'b0;
        @(negedge clk);
        ib.req0_valid = 1'b1; ib.req0_data = 32'h5A5A5A5A;
        #1; chk("b_accept_ready0", ib.req0_ready, 1'b1);
        @(negedge clk);
        ib.req0_valid = 1'b0;
        #1;
        chk("b_accept_pulse", pulse_b, 1'b1);
        chk("b_accept_disp", disp_b, 64'h5A5A5A5A);
        @(negedge clk);
        reset_b = 1'b1; ib.req1_valid = 1'b1; ib.req1_data = 32'h00000077;
        #1; chk("b_reset_cycle_ready1", ib.req1_ready, 1'b0);
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk("b_after_reset_disp", disp_b, 64'h0);
        chk("b_after_reset_pulse", pulse_b, 1'b0);
        chk("b_after_reset_last", last_b, 1'b1);
        chk("b_after_reset_ready1", ib.req1_ready, 1'b1);
        @(negedge clk);
        ib.req1_valid = 1'b0;
        #1;
        chk("b_req1_disp", disp_b, {32'h00000077, 32'h0});
        chk("b_req1_pulse", pulse_b, 1'b1);
        chk("b_req1_last", last_b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
